// File: rtl/mx_int_block_quantizer.sv
// mx_int_block_quantizer: streaming FP32 -> MXINT block quantizer.
// Buffers BLOCK_SIZE floats, derives a shared E8M0 scale, emits ints.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake, in_data = {sign, exp, man}
//   rnd_mode              0 = RNE, 1 = truncate (taken with element 0)
//   out_valid/out_ready   output handshake
//   out_scale, out_nan    block scale and NaN/Inf flag, held per block
//   out_elem/idx/last     quantized element, index, last-of-block
module mx_int_block_quantizer #(
   parameter int BLOCK_SIZE   = 32,
   parameter int ELEM_WIDTH   = 8,
   parameter int FP_EXP_WIDTH = 8,
   parameter int FP_MAN_WIDTH = 23
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [FP_EXP_WIDTH+FP_MAN_WIDTH:0]       in_data,
   input  logic                                     rnd_mode,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [FP_EXP_WIDTH-1:0]                  out_scale,
   output logic [ELEM_WIDTH-1:0]                    out_elem,
   output logic [$clog2(BLOCK_SIZE)-1:0]            out_idx,
   output logic                                     out_last,
   output logic                                     out_nan
);

   localparam int EW = ELEM_WIDTH;
   localparam int FE = FP_EXP_WIDTH;
   localparam int FM = FP_MAN_WIDTH;
   localparam int DW = 1 + FE + FM;
   localparam int IW = $clog2(BLOCK_SIZE);
   localparam int MW = FM + 1;

   typedef enum logic {FILL, EMIT} state_t;

   state_t          state;
   logic [DW-1:0]   buf_q [BLOCK_SIZE];
   logic [IW-1:0]   cnt;
   logic [FE-1:0]   emax;
   logic            nan_q;
   logic            rnd_q;

   logic            accept;
   logic [FE-1:0]   in_exp;
   logic [FE-1:0]   emax_nx;
   logic            nan_nx;
   logic [FE-1:0]   scale_nx;
   logic [DW-1:0]   q_src;
   logic [FE-1:0]   q_scale;
   logic            q_nan;
   logic [EW-1:0]   q_elem;

   // Magnitude is aligned to the scale, the top EW-1 bits kept, then
   // rounded with guard/sticky; the wide shift keeps every shifted bit.
   function automatic logic [EW-1:0] quant(
      input logic [DW-1:0] d,
      input logic [FE-1:0] sc,
      input logic          nan,
      input logic          trunc
   );
      logic [FE-1:0]   e;
      logic [FE-1:0]   ee;
      logic [FE-1:0]   sh;
      logic [MW-1:0]   m;
      logic [2*MW-1:0] ext;
      logic [EW-2:0]   kept;
      logic            guard;
      logic            sticky;
      logic [EW-1:0]   mag;
      e  = d[DW-2 -: FE];
      ee = (e == '0) ? FE'(1) : e;
      m  = {|e, d[FM-1:0]};
      sh = sc - ee;
      ext = '0;
      if (32'(sh) > MW) begin
         kept   = '0;
         guard  = 1'b0;
         sticky = |m;
      end else begin
         ext    = {m, {MW{1'b0}}} >> sh;
         kept   = ext[2*MW-1 -: EW-1];
         guard  = ext[2*MW-EW];
         sticky = |ext[2*MW-EW-1:0];
      end
      mag = {1'b0, kept} + EW'(!trunc && guard && (sticky || kept[0]));
      if (mag[EW-1])
         mag = {1'b0, {(EW-1){1'b1}}};
      if (nan)
         return '0;
      return d[DW-1] ? -mag : mag;
   endfunction

   always_comb begin
      accept   = in_valid && in_ready && (state == FILL);
      in_exp   = in_data[DW-2 -: FE];
      emax_nx  = (in_exp > emax) ? in_exp : emax;
      nan_nx   = nan_q || (&in_exp);
      scale_nx = nan_nx ? '1 : ((emax_nx == '0) ? FE'(1) : emax_nx);
      // Element 0 is converted on the final accept using the scale being
      // formed; later elements use the held scale and the next pointer.
      if (state == EMIT) begin
         q_src   = buf_q[out_idx + IW'(1)];
         q_scale = out_scale;
         q_nan   = out_nan;
      end else begin
         q_src   = buf_q[0];
         q_scale = scale_nx;
         q_nan   = nan_nx;
      end
      q_elem = quant(q_src, q_scale, q_nan, rnd_q);
   end

   always_ff @(posedge clk) begin
      if (accept)
         buf_q[cnt] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         cnt       <= '0;
         emax      <= '0;
         nan_q     <= 1'b0;
         rnd_q     <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_scale <= '0;
         out_elem  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_nan   <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (accept) begin
                  cnt   <= cnt + IW'(1);
                  emax  <= emax_nx;
                  nan_q <= nan_nx;
                  if (cnt == '0)
                     rnd_q <= rnd_mode;
                  if (cnt == IW'(BLOCK_SIZE-1)) begin
                     state     <= EMIT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_scale <= scale_nx;
                     out_nan   <= nan_nx;
                     out_elem  <= q_elem;
                     out_idx   <= '0;
                     out_last  <= 1'b0;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= FILL;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                     emax      <= '0;
                     nan_q     <= 1'b0;
                     cnt       <= '0;
                     out_elem  <= '0;
                     out_idx   <= '0;
                     out_last  <= 1'b0;
                  end else begin
                     out_idx  <= out_idx + IW'(1);
                     out_last <= (out_idx + IW'(1)) == IW'(BLOCK_SIZE-1);
                     out_elem <= q_elem;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_mx_int_block_quantizer.sv
// tb_mx_int_block_quantizer: scoreboard bench for the MXINT quantizer.
// Expected elements are queued at stimulus time and popped on handshake.
module tb_mx_int_block_quantizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        rnd_mode;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_scale;
   logic [7:0]  out_elem;
   logic [4:0]  out_idx;
   logic        out_last;
   logic        out_nan;

   always #5 clk = ~clk;

   mx_int_block_quantizer #(
      .BLOCK_SIZE(32), .ELEM_WIDTH(8), .FP_EXP_WIDTH(8), .FP_MAN_WIDTH(23)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rnd_mode(rnd_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_scale(out_scale), .out_elem(out_elem), .out_idx(out_idx),
      .out_last(out_last), .out_nan(out_nan)
   );

   typedef struct {
      logic [7:0] scale;
      logic [7:0] elem;
      logic [4:0] idx;
      logic       last;
      logic       nan;
   } sb_t;

   sb_t         sb[$];
   logic [31:0] blk[32];
   int          n_checks = 0;
   int          n_fail = 0;

   // Reference: exact integer ratio m*2^6 / 2^(23+shift), then round.
   function automatic logic [7:0] ref_q(input logic [31:0] f,
                                        input logic [7:0] sc,
                                        input bit nan, input bit rnd);
      int e, d;
      longint m, num, q, rem, half;
      if (nan) return 8'h00;
      e = int'(f[30:23]);
      m = longint'(f[22:0]);
      if (e != 0) m = m + (longint'(1) << 23);
      if (e == 0) e = 1;
      d = 23 + int'(sc) - e;
      num = m << 6;
      if (d > 40) begin
         q = 0;
      end else begin
         q = num >> d;
         rem = num - (q << d);
         half = longint'(1) << (d - 1);
         if (!rnd && (rem > half || (rem == half && q[0]))) q = q + 1;
      end
      if (q > 127) q = 127;
      return f[31] ? 8'(-q) : 8'(q);
   endfunction

   task automatic push_exp(input logic [7:0] sc, input logic [7:0] el,
                           input int i, input logic nan);
      sb_t s;
      s.scale = sc; s.elem = el; s.idx = 5'(i);
      s.last = (i == 31); s.nan = nan;
      sb.push_back(s);
   endtask

   task automatic push_model(input bit rnd);
      logic [7:0] emax = 8'h00;
      logic [7:0] sc;
      bit nan = 0;
      for (int i = 0; i < 32; i++) begin
         if (blk[i][30:23] == 8'hFF) nan = 1;
         if (blk[i][30:23] > emax) emax = blk[i][30:23];
      end
      sc = nan ? 8'hFF : ((emax == 8'h00) ? 8'h01 : emax);
      for (int i = 0; i < 32; i++)
         push_exp(sc, ref_q(blk[i], sc, nan, rnd), i, nan);
   endtask

   task automatic feed(input logic rnd);
      int t = 0;
      while (in_ready !== 1'b1 && t < 100) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 100) begin
         n_checks++; n_fail++;
         $display("FAIL feed_wait: in_ready=%b required 1", in_ready);
      end
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1; in_data = blk[i]; rnd_mode = rnd;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rnd_mode = ~rnd;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL latency: out_valid=%b in_ready=%b required 1/0",
                  out_valid, in_ready);
      end
   endtask

   task automatic drain(input int pct, input int max_hs);
      int hs = 0;
      int t = 0;
      logic v;
      while (sb.size() > 0 && hs < max_hs && t < 2000) begin
         out_ready = ($urandom_range(99) < pct);
         v = out_valid;
         if (out_valid === 1'b1) begin
            n_checks++;
            if (out_elem !== sb[0].elem || out_idx !== sb[0].idx ||
                out_last !== sb[0].last || out_scale !== sb[0].scale ||
                out_nan !== sb[0].nan) begin
               n_fail++;
               $display("FAIL drain: got sc=%h el=%h idx=%0d last=%b nan=%b required sc=%h el=%h idx=%0d last=%b nan=%b",
                        out_scale, out_elem, out_idx, out_last, out_nan,
                        sb[0].scale, sb[0].elem, sb[0].idx, sb[0].last,
                        sb[0].nan);
            end
         end
         @(posedge clk); #1;
         if (v === 1'b1 && out_ready) begin
            void'(sb.pop_front());
            hs++;
         end
         t++;
      end
      out_ready = 1'b0;
      if (t >= 2000) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout: %0d handshakes required %0d",
                  hs, max_hs);
      end
   endtask

   task automatic check_idle(input string nm);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: out_valid=%b in_ready=%b required 0/1",
                  nm, out_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      rnd_mode = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_scale, out_elem, out_idx,
           out_last, out_nan} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b vld=%b sc=%h el=%h idx=%0d last=%b nan=%b required all 0",
                  in_ready, out_valid, out_scale, out_elem, out_idx,
                  out_last, out_nan);
      end
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_clear_cycle: in_ready=%b required 0", in_ready);
      end
      @(posedge clk); #1;
      check_idle("reset_release");
   endtask

   task automatic test_ones;
      for (int i = 0; i < 32; i++) blk[i] = 32'h3F800000;
      for (int i = 0; i < 32; i++) push_exp(8'h7F, 8'h40, i, 1'b0);
      feed(1'b0);
      drain(100, 32);
      check_idle("ones_end");
   endtask

   task automatic test_mixed;
      for (int i = 0; i < 32; i++) blk[i] = 32'h0;
      blk[0] = 32'h40000000; blk[1] = 32'h3F800000; blk[2] = 32'hBF800000;
      push_exp(8'h80, 8'h40, 0, 1'b0);
      push_exp(8'h80, 8'h20, 1, 1'b0);
      push_exp(8'h80, 8'hE0, 2, 1'b0);
      for (int i = 3; i < 32; i++) push_exp(8'h80, 8'h00, i, 1'b0);
      feed(1'b0);
      drain(100, 32);
   endtask

   task automatic test_rounding;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 32; i++) blk[i] = 32'h0;
         blk[0] = 32'h3F800000; blk[1] = 32'h3F810000; blk[2] = 32'h3F830000;
         push_exp(8'h7F, 8'h40, 0, 1'b0);
         push_exp(8'h7F, 8'h40, 1, 1'b0);
         push_exp(8'h7F, (r == 0) ? 8'h42 : 8'h41, 2, 1'b0);
         for (int i = 3; i < 32; i++) push_exp(8'h7F, 8'h00, i, 1'b0);
         feed(1'(r));
         drain(100, 32);
      end
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 32; i++) blk[i] = 32'h0;
      blk[0] = 32'h3FFFFFFF; blk[1] = 32'hBFFFFFFF;
      push_exp(8'h7F, 8'h7F, 0, 1'b0);
      push_exp(8'h7F, 8'h81, 1, 1'b0);
      for (int i = 2; i < 32; i++) push_exp(8'h7F, 8'h00, i, 1'b0);
      feed(1'b0);
      drain(100, 32);
   endtask

   task automatic test_nan_zero;
      for (int i = 0; i < 32; i++)
         blk[i] = {1'($urandom_range(1)), 8'($urandom_range(254)),
                   23'($urandom)};
      blk[7] = 32'h7FC00000;
      for (int i = 0; i < 32; i++) push_exp(8'hFF, 8'h00, i, 1'b1);
      feed(1'b0);
      drain(100, 32);
      for (int i = 0; i < 32; i++) blk[i] = 32'h0;
      blk[3] = 32'h80000000;
      for (int i = 0; i < 32; i++) push_exp(8'h01, 8'h00, i, 1'b0);
      feed(1'b0);
      drain(100, 32);
   endtask

   task automatic rand_block;
      for (int i = 0; i < 32; i++)
         blk[i] = {1'($urandom_range(1)), 8'($urandom_range(130, 100)),
                   23'($urandom)};
   endtask

   task automatic test_backpressure_reset;
      bit r;
      rand_block();
      r = 1'($urandom_range(1));
      push_model(r);
      feed(r);
      drain(45, 32);
      check_idle("stall_end");
      rand_block();
      push_model(1'b0);
      feed(1'b0);
      drain(100, 5);
      out_ready = 1'b0;
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_emit_reset: out_valid=%b required 0", out_valid);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("post_reset");
      rand_block();
      push_model(1'b1);
      feed(1'b1);
      drain(70, 32);
      check_idle("fresh_end");
   endtask

   initial begin
      test_reset();
      test_ones();
      test_mixed();
      test_rounding();
      test_saturation();
      test_nan_zero();
      test_backpressure_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mx_int_block_quantizer.md
Name: mx_int_block_quantizer

Overview:
- Streaming FP32-to-MXINT quantizer: accepts BLOCK_SIZE scalar floats one per handshake and buffers the whole block.
- Derives the shared E8M0 scale from the block's largest exponent.
- Emits the scale plus BLOCK_SIZE two's-complement integer elements, one per output handshake.
- Sits upstream of the MX ALU datapath; a generalised, parametrised successor of the fixed MXINT8 element and FP32 stimulus models, with configurable element width, block size and rounding mode.

Parameters:
- BLOCK_SIZE, 32: elements per MX block (power of 2, >=2).
- ELEM_WIDTH, 8: output element width; format is sign, 1 integer bit, ELEM_WIDTH-2 fraction bits.
- FP_EXP_WIDTH, 8: input exponent width; also the scale width (scale = biased exponent).
- FP_MAN_WIDTH, 23: input mantissa width (ELEM_WIDTH-2 < FP_MAN_WIDTH).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts input.
- in_data  in  1+FP_EXP_WIDTH+FP_MAN_WIDTH  IEEE-style float {sign, exp, man}.
- rnd_mode  in  1  0 = round-nearest-even, 1 = truncate toward zero; sampled with the first element of each block.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts output.
- out_scale  out  FP_EXP_WIDTH  shared block scale, constant across the block.
- out_elem  out  ELEM_WIDTH  quantized element.
- out_idx  out  clog2(BLOCK_SIZE)  element index within the block.
- out_last  out  1  high with element BLOCK_SIZE-1.
- out_nan  out  1  block contains NaN/Inf.

Behaviour:
- Reset (applies while rst is high and on the cycle it clears):
  - in_ready=0, out_valid=0, out_scale=0, out_elem=0, out_idx=0, out_last=0, out_nan=0.
  - State=FILL, fill count=0, running emax=0, NaN flag=0.
  - First cycle after rst is low: in_ready=1.
- FILL:
  - in_ready=1, out_valid=0.
  - Each in_valid&in_ready stores in_data at buffer[count], then count++.
  - Updates emax = max(emax, exp field).
  - Sets the NaN flag if exp is all ones (Inf is treated as NaN).
  - rnd_mode is latched on count==0.
  - On the accept with count==BLOCK_SIZE-1: go to EMIT. in_ready drops the next cycle, and the first out_valid appears that same next cycle (latency 1 after the last accept).
- Scale:
  - If the NaN flag is set: 2^FP_EXP_WIDTH-1 (0xFF).
  - Otherwise: max(emax, 1). An all-zero or subnormal-only block gives 0x01.
  - out_scale and out_nan are registered on entry to EMIT and held for the whole block.
- Element conversion (per element at the read pointer):
  - Effective exponent e' = max(e, 1). Hidden bit = (e != 0).
  - Magnitude m = {hidden, man}, shifted right by scale - e'.
  - Keep the top ELEM_WIDTH-1 bits (integer bit + ELEM_WIDTH-2 fraction bits). Guard = next bit; sticky = OR of all remaining bits, including any shifted out.
  - If the shift exceeds FP_MAN_WIDTH+1: kept bits = 0, guard = 0, sticky = (m != 0).
  - RNE: increment if guard & (sticky | lsb).
  - Truncate: no increment.
  - If the rounded magnitude is >= 2^(ELEM_WIDTH-1): saturate to 2^(ELEM_WIDTH-1)-1.
  - If sign: negate (two's complement). The result is never -2^(ELEM_WIDTH-1); -0 gives 0.
  - NaN block: every out_elem = 0.
- EMIT:
  - out_valid=1. out_elem, out_idx and out_last reflect the read pointer.
  - Outputs are held stable while out_valid & !out_ready.
  - Each out_valid&out_ready advances the pointer.
  - Handshake with out_last=1: next cycle go to FILL, in_ready=1, out_valid=0, emax/NaN/count cleared.
- Single buffer: input and output never overlap. in_ready=0 throughout EMIT, and in_valid is ignored there.
- rst asserted in any state (including mid-FILL or mid-EMIT) discards the partial block; no output element is produced for it.

Test Plan:
1. 32x 0x3F800000 (1.0), out_ready=1 → out_scale=0x7F; every out_elem=0x40; out_idx 0..31; out_last only on idx 31; first out_valid 1 cycle after the 32nd accept.
2. elem0=0x40000000 (2.0), elem1=0x3F800000, elem2=0xBF800000, rest 0 → scale=0x80; elements 0x40, 0x20, 0xE0, then 0x00.
3. Max 1.0 with elem1=0x3F810000 (64.5 LSB) and elem2=0x3F830000 (65.5):
   - rnd_mode=0 → 0x40, 0x42.
   - rnd_mode=1 → 0x40, 0x41.
4. Block max 0x3FFFFFFF and element 0xBFFFFFFF, RNE → 0x7F and 0x81 (saturation, never 0x80).
5. One element 0x7FC00000 among random values → out_scale=0xFF, out_nan=1, all 32 out_elem=0x00; all-zero block → scale=0x01, all elements 0x00.
6. out_ready toggled randomly → no drop or duplicate, outputs stable while stalled. rst pulsed after 5 EMIT handshakes → next cycle out_valid=0; after release, a fresh block converts correctly with idx restarting at 0.
